// File: rtl/ysyx_22050133_axi_rw_slave_pkg.sv
// Shared encodings and helpers for the ysyx_22050133 AXI-like rw slave.
// Size/burst codes, FSM states and request legality checks.
package ysyx_22050133_axi_rw_slave_pkg;

  localparam logic [2:0] SIZE_BYTES_1 = 3'd0;
  localparam logic [2:0] SIZE_BYTES_2 = 3'd1;
  localparam logic [2:0] SIZE_BYTES_4 = 3'd2;
  localparam logic [2:0] SIZE_BYTES_8 = 3'd3;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ
  } rw_state_e;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) ||
           (len == 8'd7) || (len == 8'd15);
  endfunction

  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    return (size > SIZE_BYTES_8) ? SIZE_BYTES_8 : size;
  endfunction

endpackage

// File: rtl/ysyx_22050133_axi_rw_slave_sram.sv
// Single-port 64-bit SRAM, synchronous read, per-byte write mask.
// Read data only changes on an enabled read cycle.
module ysyx_22050133_sram_1p64 #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wmask,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem [WORDS];

  // byte-masked write or registered read
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 8; b++) begin
          if (wmask[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/ysyx_22050133_axi_rw_slave.sv
// Burst read/write slave over a 64-bit single-port SRAM.
// FIXED/INCR/WRAP bursts, narrow sizes, byte-lane justification.
module ysyx_22050133_axi_rw_slave
  import ysyx_22050133_axi_rw_slave_pkg::*;
#(
  parameter int RW_DATA_WIDTH = 64,
  parameter int RW_ADDR_WIDTH = 32,
  parameter int MEM_WORDS     = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rw_addr_valid_i,
  output logic                     rw_addr_ready_o,
  input  logic [RW_ADDR_WIDTH-1:0] rw_addr_i,
  input  logic                     rw_we_i,
  input  logic [7:0]               rw_len_i,
  input  logic [2:0]               rw_size_i,
  input  logic [1:0]               rw_burst_i,
  input  logic                     rw_if_i,
  input  logic                     w_data_valid_i,
  output logic                     w_data_ready_o,
  input  logic [RW_DATA_WIDTH-1:0] w_data_i,
  output logic                     r_data_valid_o,
  input  logic                     r_data_ready_i,
  output logic [RW_DATA_WIDTH-1:0] r_data_o,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int IW = $clog2(MEM_WORDS);

  rw_state_e              state;
  logic [RW_ADDR_WIDTH-1:0] addr_q;
  logic [RW_ADDR_WIDTH-1:0] nxt;
  logic [RW_ADDR_WIDTH-1:0] step;
  logic [RW_ADDR_WIDTH-1:0] inc;
  logic [RW_ADDR_WIDTH-1:0] wrap_mask;
  logic [7:0]             len_q;
  logic [7:0]             cnt;
  logic [2:0]             size_q;
  logic [1:0]             burst_q;
  logic                   rvalid_q;
  logic                   err_q;
  logic                   if_unused_q;

  logic          accept;
  logic          wr_hs;
  logic          rd_hs;
  logic          last;
  logic          bad_wrap;
  logic          req_bad;
  logic [2:0]    req_size;
  logic [1:0]    req_burst;

  logic          sram_en;
  logic          sram_we;
  logic [IW-1:0] sram_addr;
  logic [7:0]    sram_be;
  logic [63:0]   sram_wdata;
  logic [63:0]   sram_q;
  logic [7:0]    be_base;
  logic [5:0]    shamt;
  logic [63:0]   rsh;
  logic [63:0]   rd64;

  assign rw_addr_ready_o = (state == ST_IDLE) & ~rst;
  assign w_data_ready_o  = (state == ST_WRITE) & ~rst;
  assign busy_o          = state != ST_IDLE;
  assign r_data_valid_o  = rvalid_q;
  assign err_o           = err_q;

  assign accept = rw_addr_valid_i & rw_addr_ready_o;
  assign wr_hs  = w_data_valid_i & w_data_ready_o;
  assign rd_hs  = rvalid_q & r_data_ready_i;
  assign last   = cnt == 8'd0;

  assign bad_wrap  = (rw_burst_i == BURST_WRAP) & ~wrap_len_ok(rw_len_i);
  assign req_bad   = bad_wrap | (rw_size_i > SIZE_BYTES_8);
  assign req_size  = clamp_size(rw_size_i);
  assign req_burst = bad_wrap ? BURST_INCR : rw_burst_i;

  // next beat address for the latched burst type
  always_comb begin
    step      = RW_ADDR_WIDTH'(1) << size_q;
    inc       = addr_q + step;
    wrap_mask = (RW_ADDR_WIDTH'({1'b0, len_q} + 9'd1) << size_q)
              - RW_ADDR_WIDTH'(1);
    nxt = inc;
    unique case (1'b1)
      burst_q == BURST_FIXED: nxt = addr_q;
      burst_q == BURST_WRAP:
        nxt = (addr_q & ~wrap_mask) | (inc & wrap_mask);
      default: nxt = inc;
    endcase
  end

  // sram port: prefetch on accept or read beat, write on w handshake
  always_comb begin
    sram_en = (accept & ~rw_we_i) | (rd_hs & ~last) | wr_hs;
    sram_we = wr_hs;
    unique case (1'b1)
      state == ST_IDLE: sram_addr = rw_addr_i[IW+2:3];
      state == ST_READ: sram_addr = nxt[IW+2:3];
      default:          sram_addr = addr_q[IW+2:3];
    endcase
  end

  // lane alignment of write data and read extraction
  always_comb begin
    shamt = {addr_q[2:0], 3'b000};
    unique case (size_q)
      SIZE_BYTES_1: be_base = 8'h01;
      SIZE_BYTES_2: be_base = 8'h03;
      SIZE_BYTES_4: be_base = 8'h0F;
      default:      be_base = 8'hFF;
    endcase
    sram_be    = be_base << addr_q[2:0];
    sram_wdata = 64'(w_data_i) << shamt;
    rsh        = sram_q >> shamt;
    unique case (size_q)
      SIZE_BYTES_1: rd64 = {56'd0, rsh[7:0]};
      SIZE_BYTES_2: rd64 = {48'd0, rsh[15:0]};
      SIZE_BYTES_4: rd64 = {32'd0, rsh[31:0]};
      default:      rd64 = rsh;
    endcase
  end

  assign r_data_o = rvalid_q ? RW_DATA_WIDTH'(rd64) : '0;

  // burst FSM, beat counter and latched request
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= 8'd0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      len_q       <= 8'd0;
      size_q      <= SIZE_BYTES_8;
      burst_q     <= BURST_INCR;
      if_unused_q <= 1'b0;
    end else begin
      err_q <= accept & req_bad;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            state       <= rw_we_i ? ST_WRITE : ST_READ;
            cnt         <= rw_len_i;
            rvalid_q    <= ~rw_we_i;
            addr_q      <= rw_addr_i;
            len_q       <= rw_len_i;
            size_q      <= req_size;
            burst_q     <= req_burst;
            if_unused_q <= rw_if_i;
          end
        end
        ST_WRITE: begin
          if (wr_hs) begin
            if (last) begin
              state <= ST_IDLE;
            end else begin
              cnt    <= cnt - 8'd1;
              addr_q <= nxt;
            end
          end
        end
        ST_READ: begin
          if (rd_hs) begin
            if (last) begin
              state    <= ST_IDLE;
              rvalid_q <= 1'b0;
            end else begin
              cnt    <= cnt - 8'd1;
              addr_q <= nxt;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ysyx_22050133_sram_1p64 #(
    .WORDS(MEM_WORDS)
  ) u_sram (
    .clk  (clk),
    .en   (sram_en),
    .we   (sram_we),
    .addr (sram_addr),
    .wmask(sram_be),
    .wdata(sram_wdata),
    .rdata(sram_q)
  );

endmodule
